// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: FSM states and peripheral window bounds for lint2apb_bridge
package apb_bridge_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  localparam logic [31:0] APB_WIN_BASE = 32'h4A10_0000;
  localparam logic [31:0] APB_WIN_END  = 32'h4A11_7FFF;
endpackage

// File: rtl/lint2apb_bridge_if.sv
// lint2apb_bridge_if: core req/gnt/rvalid port plus APB bus; master = bridge, slave = core and peripherals
interface lint2apb_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    data_req_i;
  logic                    data_gnt_o;
  logic [ADDR_WIDTH-1:0]   data_addr_i;
  logic                    data_we_i;
  logic [DATA_WIDTH/8-1:0] data_be_i;
  logic [DATA_WIDTH-1:0]   data_wdata_i;
  logic                    data_rvalid_o;
  logic [DATA_WIDTH-1:0]   data_rdata_o;
  logic                    data_err_o;
  logic [ADDR_WIDTH-1:0]   apb_paddr_o;
  logic [DATA_WIDTH-1:0]   apb_pwdata_o;
  logic                    apb_pwrite_o;
  logic                    apb_psel_o;
  logic                    apb_penable_o;
  logic [DATA_WIDTH-1:0]   apb_prdata_i;
  logic                    apb_pready_i;
  logic                    apb_pslverr_i;
  modport master (
    input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output apb_paddr_o, apb_pwdata_o, apb_pwrite_o, apb_psel_o, apb_penable_o,
    input  apb_prdata_i, apb_pready_i, apb_pslverr_i
  );
  modport slave (
    output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  apb_paddr_o, apb_pwdata_o, apb_pwrite_o, apb_psel_o, apb_penable_o,
    output apb_prdata_i, apb_pready_i, apb_pslverr_i
  );
endinterface

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: ACCESS-phase wait counter, present only when APB_BRIDGE_TIMEOUT_EN is defined
`ifdef APB_BRIDGE_TIMEOUT_EN
module apb_timeout_cnt #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] r_cnt;
  assign o_expired = r_cnt == W'(LIMIT);
  // count stalled ACCESS cycles, restarting each time ACCESS is entered
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_cnt <= '0;
    else if (i_en && !o_expired) r_cnt <= r_cnt + 1'b1;
  end
endmodule
`endif

// File: rtl/lint2apb_bridge.sv
// lint2apb_bridge: single-outstanding req/gnt to APB3 bridge; APB_BRIDGE_TIMEOUT_EN enables the ACCESS timeout
module lint2apb_bridge
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  lint2apb_bridge_if.master bus
);
  state_t                r_state, w_state_nxt;
  logic                  r_psel, r_penable, r_pwrite, r_rvalid, r_err, w_err_nxt;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata, r_rdata, w_rdata_nxt;
  logic                  w_gnt, w_in_win, w_expired, w_unused;
  assign w_gnt    = bus.data_req_i & ~rst & (r_state == IDLE);
  assign w_in_win = bus.data_addr_i >= ADDR_WIDTH'(APB_WIN_BASE) && bus.data_addr_i <= ADDR_WIDTH'(APB_WIN_END);
  assign w_unused = ^bus.data_be_i ^ (TIMEOUT_CYCLES == 0);
`ifdef APB_BRIDGE_TIMEOUT_EN
  apb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (r_state == SETUP),
    .i_en      (r_state == ACCESS && !bus.apb_pready_i),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif
  // next state and the response payload that lands with rvalid
  always_comb begin
    w_state_nxt = r_state;
    w_rdata_nxt = '0;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      IDLE: if (w_gnt) begin
        w_state_nxt = w_in_win ? SETUP : RESP;
        w_err_nxt   = ~w_in_win;
      end
      SETUP: w_state_nxt = ACCESS;
      ACCESS: if (bus.apb_pready_i) begin
        w_state_nxt = RESP;
        w_rdata_nxt = (r_pwrite || bus.apb_pslverr_i) ? '0 : bus.apb_prdata_i;
        w_err_nxt   = bus.apb_pslverr_i;
      end else if (w_expired) begin
        w_state_nxt = RESP;
        w_err_nxt   = 1'b1;
      end
      RESP: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  // state plus registered bus/response outputs derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_psel    <= w_state_nxt == SETUP || w_state_nxt == ACCESS;
      r_penable <= w_state_nxt == ACCESS;
      r_rvalid  <= w_state_nxt == RESP;
      r_rdata   <= w_rdata_nxt;
      r_err     <= w_err_nxt;
      if (w_gnt) begin
        r_paddr  <= {bus.data_addr_i[ADDR_WIDTH-1:2], 2'b00};
        r_pwdata <= bus.data_wdata_i;
        r_pwrite <= bus.data_we_i;
      end
    end
  end
  assign bus.data_gnt_o    = w_gnt;
  assign bus.data_rvalid_o = r_rvalid;
  assign bus.data_rdata_o  = r_rdata;
  assign bus.data_err_o    = r_err;
  assign bus.apb_paddr_o   = r_paddr;
  assign bus.apb_pwdata_o  = r_pwdata;
  assign bus.apb_pwrite_o  = r_pwrite;
  assign bus.apb_psel_o    = r_psel;
  assign bus.apb_penable_o = r_penable;
endmodule

// File: tb/tb_lint2apb_bridge.sv
// tb_lint2apb_bridge: directed checks of the bridge timing, window decode, waits, reset and timeout
module tb_lint2apb_bridge;
`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  lint2apb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u_if ();
  lint2apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.master)
  );
  always #5 clk = ~clk;

  task automatic start_req(input logic [31:0] addr, input logic we, input logic [31:0] wd, input logic [3:0] be);
    u_if.data_addr_i  = addr;
    u_if.data_we_i    = we;
    u_if.data_wdata_i = wd;
    u_if.data_be_i    = be;
    u_if.data_req_i   = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start_req(32'h4A10_0000, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (u_if.data_gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt got %b want 0", u_if.data_gnt_o); end
    n_checks++; if ({u_if.apb_psel_o, u_if.apb_penable_o, u_if.apb_pwrite_o, u_if.data_rvalid_o, u_if.data_err_o} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl got %b want 00000", {u_if.apb_psel_o, u_if.apb_penable_o, u_if.apb_pwrite_o, u_if.data_rvalid_o, u_if.data_err_o}); end
    n_checks++; if ({u_if.apb_paddr_o, u_if.apb_pwdata_o, u_if.data_rdata_o} !== 96'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", {u_if.apb_paddr_o, u_if.apb_pwdata_o, u_if.data_rdata_o}); end
    u_if.data_req_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read;
    u_if.apb_pready_i = 1'b1;
    u_if.apb_prdata_i = 32'hDEAD_BEEF;
    start_req(32'h4A10_3004, 1'b0, 32'h0, 4'hF);
    n_checks++; if (u_if.data_gnt_o !== 1'b1) begin n_fail++; $display("FAIL read_gnt got %b want 1", u_if.data_gnt_o); end
    @(negedge clk);
    u_if.data_req_i = 1'b0;
    n_checks++; if ({u_if.apb_psel_o, u_if.apb_penable_o} !== 2'b10) begin n_fail++; $display("FAIL read_setup got %b want 10", {u_if.apb_psel_o, u_if.apb_penable_o}); end
    n_checks++; if (u_if.apb_paddr_o !== 32'h4A10_3004 || u_if.apb_pwrite_o !== 1'b0) begin n_fail++; $display("FAIL read_addr got %h/%b want 4a103004/0", u_if.apb_paddr_o, u_if.apb_pwrite_o); end
    @(negedge clk);
    n_checks++; if ({u_if.apb_psel_o, u_if.apb_penable_o, u_if.data_rvalid_o} !== 3'b110) begin n_fail++; $display("FAIL read_access got %b want 110", {u_if.apb_psel_o, u_if.apb_penable_o, u_if.data_rvalid_o}); end
    @(negedge clk);
    n_checks++; if ({u_if.data_rvalid_o, u_if.data_err_o, u_if.apb_psel_o} !== 3'b100) begin n_fail++; $display("FAIL read_resp got %b want 100", {u_if.data_rvalid_o, u_if.data_err_o, u_if.apb_psel_o}); end
    n_checks++; if (u_if.data_rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL read_rdata got %h want deadbeef", u_if.data_rdata_o); end
    @(negedge clk);
    n_checks++; if (u_if.data_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL read_pulse got %b want 0", u_if.data_rvalid_o); end
  endtask

  task automatic test_write;
    u_if.apb_prdata_i = 32'hFFFF_0000;
    start_req(32'h4A10_1002, 1'b1, 32'h1234_5678, 4'b0011);
    n_checks++; if (u_if.data_gnt_o !== 1'b1) begin n_fail++; $display("FAIL write_gnt got %b want 1", u_if.data_gnt_o); end
    @(negedge clk);
    u_if.data_req_i = 1'b0;
    n_checks++; if (u_if.apb_paddr_o !== 32'h4A10_1000) begin n_fail++; $display("FAIL write_paddr got %h want 4a101000", u_if.apb_paddr_o); end
    n_checks++; if (u_if.apb_pwdata_o !== 32'h1234_5678 || u_if.apb_pwrite_o !== 1'b1) begin n_fail++; $display("FAIL write_pwdata got %h/%b want 12345678/1", u_if.apb_pwdata_o, u_if.apb_pwrite_o); end
    @(negedge clk);
    @(negedge clk);
    n_checks++; if ({u_if.data_rvalid_o, u_if.data_err_o} !== 2'b10 || u_if.data_rdata_o !== 32'h0) begin n_fail++; $display("FAIL write_resp got %b/%h want 10/0", {u_if.data_rvalid_o, u_if.data_err_o}, u_if.data_rdata_o); end
    @(negedge clk);
  endtask

  task automatic test_wait_err;
    u_if.apb_pready_i = 1'b0;
    u_if.apb_prdata_i = 32'h5555_AAAA;
    start_req(32'h4A10_0040, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    u_if.data_req_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if ({u_if.apb_psel_o, u_if.apb_penable_o, u_if.data_rvalid_o} !== 3'b110 || u_if.apb_paddr_o !== 32'h4A10_0040) begin n_fail++; $display("FAIL wait_stable[%0d] got %b/%h want 110/4a100040", k, {u_if.apb_psel_o, u_if.apb_penable_o, u_if.data_rvalid_o}, u_if.apb_paddr_o); end
    end
    u_if.apb_pready_i  = 1'b1;
    u_if.apb_pslverr_i = 1'b1;
    @(negedge clk);
    u_if.apb_pslverr_i = 1'b0;
    n_checks++; if ({u_if.data_rvalid_o, u_if.data_err_o, u_if.apb_psel_o} !== 3'b110) begin n_fail++; $display("FAIL wait_err_resp got %b want 110", {u_if.data_rvalid_o, u_if.data_err_o, u_if.apb_psel_o}); end
    n_checks++; if (u_if.data_rdata_o !== 32'h0) begin n_fail++; $display("FAIL wait_err_rdata got %h want 0", u_if.data_rdata_o); end
    @(negedge clk);
  endtask

  task automatic test_reject(input logic [31:0] addr);
    start_req(addr, 1'b0, 32'h0, 4'hF);
    n_checks++; if (u_if.data_gnt_o !== 1'b1) begin n_fail++; $display("FAIL reject_gnt %h got %b want 1", addr, u_if.data_gnt_o); end
    @(negedge clk);
    u_if.data_req_i = 1'b0;
    n_checks++; if ({u_if.data_rvalid_o, u_if.data_err_o, u_if.apb_psel_o} !== 3'b110 || u_if.data_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reject_resp %h got %b/%h want 110/0", addr, {u_if.data_rvalid_o, u_if.data_err_o, u_if.apb_psel_o}, u_if.data_rdata_o); end
    @(negedge clk);
    n_checks++; if ({u_if.data_rvalid_o, u_if.apb_psel_o} !== 2'b00) begin n_fail++; $display("FAIL reject_after %h got %b want 00", addr, {u_if.data_rvalid_o, u_if.apb_psel_o}); end
  endtask

  task automatic test_window_edge;
    start_req(32'h4A11_7FFC, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    u_if.data_req_i = 1'b0;
    n_checks++; if (u_if.apb_psel_o !== 1'b1) begin n_fail++; $display("FAIL win_end_psel got %b want 1", u_if.apb_psel_o); end
    @(negedge clk);
    @(negedge clk);
    n_checks++; if ({u_if.data_rvalid_o, u_if.data_err_o} !== 2'b10) begin n_fail++; $display("FAIL win_end_resp got %b want 10", {u_if.data_rvalid_o, u_if.data_err_o}); end
    @(negedge clk);
    start_req(32'h4A10_0000, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    u_if.data_req_i = 1'b0;
    n_checks++; if (u_if.apb_psel_o !== 1'b1) begin n_fail++; $display("FAIL win_base_psel got %b want 1", u_if.apb_psel_o); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    u_if.apb_pready_i = 1'b1;
    start_req(32'h4A10_0010, 1'b1, 32'hCAFE_F00D, 4'hF);
    n_checks++; if (u_if.data_gnt_o !== 1'b1) begin n_fail++; $display("FAIL b2b_first_gnt got %b want 1", u_if.data_gnt_o); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++; if (u_if.data_gnt_o !== (k == 4)) begin n_fail++; $display("FAIL b2b_gnt[T+%0d] got %b want %b", k, u_if.data_gnt_o, k == 4); end
    end
    u_if.data_req_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    u_if.apb_pready_i = 1'b0;
    start_req(32'h4A10_0020, 1'b1, 32'h0BAD_0BAD, 4'hF);
    @(negedge clk);
    u_if.data_req_i = 1'b0;
    @(negedge clk);
    n_checks++; if (u_if.apb_penable_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_access got %b want 1", u_if.apb_penable_o); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({u_if.apb_psel_o, u_if.apb_penable_o, u_if.apb_pwrite_o, u_if.data_rvalid_o, u_if.data_err_o, u_if.data_gnt_o} !== 6'b0 || {u_if.apb_paddr_o, u_if.apb_pwdata_o} !== 64'h0) begin n_fail++; $display("FAIL rstmid_outputs got %b/%h want 0", {u_if.apb_psel_o, u_if.apb_penable_o, u_if.apb_pwrite_o, u_if.data_rvalid_o, u_if.data_err_o, u_if.data_gnt_o}, {u_if.apb_paddr_o, u_if.apb_pwdata_o}); end
    rst = 1'b0;
    u_if.apb_pready_i = 1'b1;
    @(negedge clk);
    n_checks++; if ({u_if.data_rvalid_o, u_if.apb_psel_o} !== 2'b00) begin n_fail++; $display("FAIL rstmid_no_rvalid got %b want 00", {u_if.data_rvalid_o, u_if.apb_psel_o}); end
    start_req(32'h4A10_0024, 1'b0, 32'h0, 4'hF);
    n_checks++; if (u_if.data_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_regrant got %b want 1", u_if.data_gnt_o); end
    @(negedge clk);
    u_if.data_req_i = 1'b0;
    n_checks++; if (u_if.apb_psel_o !== 1'b1 || u_if.apb_paddr_o !== 32'h4A10_0024) begin n_fail++; $display("FAIL rstmid_psel got %b/%h want 1/4a100024", u_if.apb_psel_o, u_if.apb_paddr_o); end
    repeat (3) @(negedge clk);
  endtask

`ifdef APB_BRIDGE_TIMEOUT_EN
  task automatic test_timeout;
    u_if.apb_pready_i = 1'b0;
    u_if.apb_prdata_i = 32'hAAAA_AAAA;
    start_req(32'h4A10_0030, 1'b0, 32'h0, 4'hF);
    @(negedge clk);
    u_if.data_req_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if ({u_if.apb_psel_o, u_if.apb_penable_o, u_if.data_rvalid_o} !== 3'b110) begin n_fail++; $display("FAIL timeout_wait[%0d] got %b want 110", k, {u_if.apb_psel_o, u_if.apb_penable_o, u_if.data_rvalid_o}); end
    end
    @(negedge clk);
    n_checks++; if ({u_if.data_rvalid_o, u_if.data_err_o, u_if.apb_psel_o, u_if.apb_penable_o} !== 4'b1100 || u_if.data_rdata_o !== 32'h0) begin n_fail++; $display("FAIL timeout_resp got %b/%h want 1100/0", {u_if.data_rvalid_o, u_if.data_err_o, u_if.apb_psel_o, u_if.apb_penable_o}, u_if.data_rdata_o); end
    u_if.apb_pready_i = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    u_if.data_req_i    = 1'b0;
    u_if.data_addr_i   = '0;
    u_if.data_we_i     = 1'b0;
    u_if.data_be_i     = '0;
    u_if.data_wdata_i  = '0;
    u_if.apb_prdata_i  = '0;
    u_if.apb_pready_i  = 1'b1;
    u_if.apb_pslverr_i = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_wait_err();
    test_reject(32'h4A20_0000);
    test_reject(32'h4A11_8000);
    test_reject(32'h4A0F_FFFC);
    test_window_edge();
    test_back_to_back();
    test_reset_mid();
`ifdef APB_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lint2apb_bridge.md
# lint2apb_bridge

Single-outstanding bridge from the core-side data request port (req/gnt/rvalid protocol) to the SoC peripheral APB bus. It sits directly upstream of the peripheral APB bus and its slave decoder, and drives the bus as its only master. It converts each granted request into one APB3 setup/access transfer and returns the read data and error status as a single rvalid pulse. Addresses outside the peripheral window are rejected without any bus activity.

## Interface
- ADDR_WIDTH, 32, address width on both sides
- DATA_WIDTH, 32, data width on both sides
- TIMEOUT_CYCLES, 255, ACCESS-phase wait limit (used only with the timeout macro)

- clk  in  1  single clock; one clock; reset is synchronous and active-high
- rst  in  1  synchronous, active-high reset
- data_req_i  in  1  request valid
- data_gnt_o  out  1  request accepted (combinational)
- data_addr_i  in  ADDR_WIDTH  byte address
- data_we_i  in  1  1 = write
- data_be_i  in  DATA_WIDTH/8  byte enables (ignored; peripherals are word-only)
- data_wdata_i  in  DATA_WIDTH  write data
- data_rvalid_o  out  1  response pulse
- data_rdata_o  out  DATA_WIDTH  read data (0 for writes and errors)
- data_err_o  out  1  error flag, valid with rvalid
- apb_paddr_o / apb_pwdata_o  out  ADDR_WIDTH / DATA_WIDTH  APB address (bits [1:0] forced 0) / write data
- apb_pwrite_o, apb_psel_o, apb_penable_o  out  1  APB controls
- apb_prdata_i  in  DATA_WIDTH;  apb_pready_i, apb_pslverr_i  in  1  APB responses

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: data_gnt_o = data_req_i & ~rst. On grant, the bridge captures addr, we and wdata.
  - Address in [APB_WIN_BASE, APB_WIN_END]: go to SETUP.
  - Any other address: go to RESP with err=1.
- SETUP: psel=1, penable=0. Always go to ACCESS.
- ACCESS: psel=1, penable=1. Hold paddr, pwdata and pwrite stable.
  - On pready=1: latch prdata (reads only, else 0), latch pslverr into err, go to RESP.
- RESP: rvalid=1 for exactly one cycle with rdata/err, then go to IDLE. psel and penable are 0.
- data_gnt_o is 0 in every state except IDLE, so at most one transaction is outstanding.
- A request presented in SETUP, ACCESS or RESP is held by the requester until IDLE.
- data_be_i is ignored. Sub-word writes are issued as full-word writes.
- Reset mid-transfer: the next edge forces IDLE and drives all outputs to reset values. The APB transfer is abandoned and no rvalid is issued.

## Timing
- Reset values: psel, penable, pwrite, paddr, pwdata, rvalid, rdata, err = 0. gnt = 0 while rst=1.
- All APB outputs and response outputs are registered. Only gnt is combinational.
- Grant in cycle T gives:
  - psel rising at T+1
  - penable at T+2
  - if pready is high at T+2, rvalid at T+3
- Each pready wait cycle adds one cycle of latency.
- Out-of-window grant at T gives rvalid with err=1 at T+1. psel stays 0 throughout.
- Minimum spacing between grants is 4 cycles for a valid access and 2 cycles for a rejected one.

## Configuration
- APB_BRIDGE_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments each cycle that pready=0.
  - When the count equals TIMEOUT_CYCLES with pready still 0, psel and penable drop and the FSM goes to RESP with err=1 and rdata=0.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
  - pready=1 in the same cycle as the limit wins, giving a normal completion.
- APB_BRIDGE_TIMEOUT_EN undefined: no counter. ACCESS waits for pready indefinitely.

## Structure
- Package apb_bridge_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS/RESP)
  - APB_WIN_BASE = 32'h4A10_0000 and APB_WIN_END = 32'h4A11_7FFF, aligned with the peripheral address map
- Sub-module apb_timeout_cnt (clear, enable, expired output) holds the timeout counter. It is instantiated only under the macro.

## Test plan
- Read at 0x4A10_3004, pready=1 immediately, prdata=0xDEAD_BEEF:
  - psel at T+1, penable at T+2
  - rvalid at T+3 with rdata=0xDEAD_BEEF, err=0
- Write 0x1234_5678 to 0x4A10_1002 with be=4'b0011:
  - paddr=0x4A10_1000, pwdata=0x1234_5678, pwrite=1
  - rdata=0, err=0
- Read with pready low for 3 ACCESS cycles and pslverr=1 on completion:
  - rvalid at T+6 with err=1
  - psel/penable stable throughout the wait
- Request to 0x4A20_0000:
  - gnt at T, no psel at any point
  - rvalid with err=1 at T+1
- Back-to-back requests held high:
  - second gnt only in IDLE, exactly 4 cycles after the first
- rst asserted during ACCESS:
  - next cycle all outputs are 0 and no rvalid is issued
  - a new request is granted once rst=0
- With APB_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready held 0:
  - after 4 wait cycles, rvalid with err=1 and rdata=0, and psel drops
